mc_control_unit: RTL and testbench

- Moore FSM controller for the multicycle MIPS-subset datapath.
- Sequences every datapath select and write-enable: PC/IR/register file/memory writes, ALU source A/B muxes, ALU operation, PC source, memory address select.
- Decodes opcode/funct from the IR.
- Sits beside the datapath top; the only block that drives ALUSrcB.

---
 rtl/cpu_ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_alu_decode.sv | 24 ++
 rtl/mc_control_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller.
// The EXC state exists only when CTRL_OVF_EXC_EN is defined.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_R_EXEC    = 5'd3,
        S_R_WB      = 5'd4,
        S_ADDI_EXEC = 5'd5,
        S_ADDI_WB   = 5'd6,
        S_MEM_ADDR  = 5'd7,
        S_LW_READ   = 5'd8,
        S_LW_WB     = 5'd9,
        S_SW_WRITE  = 5'd10,
        S_BEQ       = 5'd11,
        S_JUMP      = 5'd12
`ifdef CTRL_OVF_EXC_EN
        ,
        S_EXC       = 5'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCB_RT       = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SL2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_write;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_alu_decode.sv
// R-type funct to ALUOp map, with a legal-funct flag and an add/sub flag
// (the latter marks the funct codes that can raise signed overflow).
module ctrl_alu_decode (
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid,
    output logic       addsub
);
    import cpu_ctrl_pkg::*;

    always_comb begin
        alu_op = ALU_NOP;
        valid  = 1'b0;
        addsub = 1'b0;
        case (funct)
            FN_ADD: begin alu_op = ALU_ADD; valid = 1'b1; addsub = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; valid = 1'b1; addsub = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; valid = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  valid = 1'b1; end
            FN_SLT: begin alu_op = ALU_SLT; valid = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Moore control FSM for the multicycle MIPS-subset datapath.
// Optional overflow exception state enabled by defining CTRL_OVF_EXC_EN.
//
// state       | meaning
// S_RESET     | all outputs low, go to fetch
// S_FETCH     | read instruction for MEM_WAIT cycles, last cycle loads IR and PC+4
// S_DECODE    | latch opcode/funct, ALUOut <= branch target
// S_R_EXEC    | rs op rt
// S_R_WB      | rd <= ALUOut
// S_ADDI_EXEC | rs + sext(imm)
// S_ADDI_WB   | rt <= ALUOut
// S_MEM_ADDR  | effective address rs + sext(imm)
// S_LW_READ   | data read for MEM_WAIT cycles
// S_LW_WB     | rt <= MDR
// S_SW_WRITE  | single-cycle store
// S_BEQ       | compare rs/rt, PC <= ALUOut if zero
// S_JUMP      | PC <= jump target
// S_EXC       | EPC <= PC-4, PC <= exception vector
module mc_control_unit #(
    parameter int         MEM_WAIT       = 1,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic [4:0] state
);
    import cpu_ctrl_pkg::*;

    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      op_q, fn_q, fn_sel;
    logic            last_q, last_d;
    logic [2:0]      fn_alu_op;
    logic            fn_valid, fn_addsub;
    ctrl_out_t       out_q, out_d;

    // In DECODE the live funct feeds both the transition and the R_EXEC outputs.
    assign fn_sel = (state_q == S_DECODE) ? funct : fn_q;

    ctrl_alu_decode u_alu_decode (
        .funct  (fn_sel),
        .alu_op (fn_alu_op),
        .valid  (fn_valid),
        .addsub (fn_addsub)
    );

    assign last_q = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     state_d = last_q ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = fn_valid ? S_R_EXEC : S_FETCH;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_R_EXEC: begin
                state_d = S_R_WB;
`ifdef CTRL_OVF_EXC_EN
                if (overflow && fn_addsub) state_d = S_EXC;
`endif
            end
            S_ADDI_EXEC: begin
                state_d = S_ADDI_WB;
`ifdef CTRL_OVF_EXC_EN
                if (overflow) state_d = S_EXC;
`endif
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:   state_d = last_q ? S_LW_WB : S_LW_READ;
            default:     state_d = S_FETCH;
        endcase
    end

    // Only FETCH and LW_READ ever stay put, and only while not on the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (!last_q)       cnt_d = cnt_q + CW'(1);
    end

    assign last_d = (cnt_d == CNT_LAST);

    // Outputs are registered, so they are computed from the upcoming state/count.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH: begin
                out_d.mem_read = 1'b1;
                if (last_d) begin
                    out_d.ir_write  = 1'b1;
                    out_d.pc_write  = 1'b1;
                    out_d.alu_src_b = SRCB_FOUR;
                    out_d.alu_op    = ALU_ADD;
                    out_d.pc_source = PCS_ALU;
                end
            end
            S_DECODE: begin
                out_d.alu_src_b = SRCB_SEXT_SL2;
                out_d.alu_op    = ALU_ADD;
            end
            S_R_EXEC: begin
                out_d.alu_src_a = 1'b1;
                out_d.alu_src_b = SRCB_RT;
                out_d.alu_op    = fn_alu_op;
            end
            S_R_WB: begin
                out_d.reg_dst   = 1'b1;
                out_d.reg_write = 1'b1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                out_d.alu_src_a = 1'b1;
                out_d.alu_src_b = SRCB_SEXT;
                out_d.alu_op    = ALU_ADD;
            end
            S_ADDI_WB:  out_d.reg_write = 1'b1;
            S_LW_READ: begin
                out_d.mem_read = 1'b1;
                out_d.iord     = 1'b1;
            end
            S_LW_WB: begin
                out_d.mem_to_reg = 1'b1;
                out_d.reg_write  = 1'b1;
            end
            S_SW_WRITE: begin
                out_d.mem_write = 1'b1;
                out_d.iord      = 1'b1;
            end
            S_BEQ: begin
                out_d.alu_src_a     = 1'b1;
                out_d.alu_src_b     = SRCB_RT;
                out_d.alu_op        = ALU_SUB;
                out_d.pc_write_cond = 1'b1;
                out_d.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                out_d.pc_write  = 1'b1;
                out_d.pc_source = PCS_JUMP;
            end
`ifdef CTRL_OVF_EXC_EN
            S_EXC: begin
                out_d.epc_write = 1'b1;
                out_d.alu_src_b = SRCB_FOUR;
                out_d.alu_op    = ALU_SUB;
                out_d.pc_write  = 1'b1;
                out_d.pc_source = EXC_VECTOR_SEL;
            end
`endif
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            out_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    assign PCWrite     = out_q.pc_write;
    assign PCWriteCond = out_q.pc_write_cond;
    assign IorD        = out_q.iord;
    assign MemRead     = out_q.mem_read;
    assign MemWrite    = out_q.mem_write;
    assign IRWrite     = out_q.ir_write;
    assign RegDst      = out_q.reg_dst;
    assign MemtoReg    = out_q.mem_to_reg;
    assign RegWrite    = out_q.reg_write;
    assign ALUSrcA     = out_q.alu_src_a;
    assign ALUSrcB     = out_q.alu_src_b;
    assign ALUOp       = out_q.alu_op;
    assign PCSource    = out_q.pc_source;
    assign state       = state_q;

    // zero is consumed by the datapath's PCWriteCond gate, not here.
    logic unused_inputs;
`ifdef CTRL_OVF_EXC_EN
    assign EPCWrite      = out_q.epc_write;
    assign unused_inputs = zero;
`else
    assign EPCWrite      = 1'b0;
    assign unused_inputs = ^{zero, overflow, fn_addsub, out_q.epc_write, EXC_VECTOR_SEL};
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Table-driven bench for mc_control_unit; runs one instance with MEM_WAIT=1
// and one with MEM_WAIT=3 against hand-computed state/output vectors.
module tb_mc_control_unit;

    localparam logic [4:0] ST_RST = 5'd0,  ST_FETCH = 5'd1, ST_DEC = 5'd2,
                           ST_REX = 5'd3,  ST_RWB = 5'd4,   ST_AEX = 5'd5,
                           ST_AWB = 5'd6,  ST_MADDR = 5'd7, ST_LWR = 5'd8,
                           ST_LWWB = 5'd9, ST_SW = 5'd10,   ST_BEQ = 5'd11,
                           ST_J = 5'd12,   ST_EXC = 5'd13;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0],EPCWrite}
    localparam logic [17:0] O_ZERO = 18'h00000, O_FW   = 18'h04000, O_FL   = 18'h25048,
                            O_DEC  = 18'h000C8, O_ADD  = 18'h00108, O_SUB  = 18'h00110,
                            O_AND  = 18'h00118, O_OR   = 18'h00120, O_SLT  = 18'h00128,
                            O_RWB  = 18'h00A00, O_IMM  = 18'h00188, O_AWB  = 18'h00200,
                            O_LWR  = 18'h0C000, O_LWWB = 18'h00600, O_SW   = 18'h0A000,
                            O_BEQ  = 18'h10112, O_J    = 18'h20004, O_EXC  = 18'h20057;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [4:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t tab[$];
    int   ncmp = 0;
    int   nfail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, overflow;
    logic [5:0] opcode, funct;

    logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, sa1, epc1;
    logic [1:0] sb1, ps1;
    logic [2:0] ao1;
    logic [4:0] st1;
    logic       pcw3, pcwc3, iord3, mr3, mw3, irw3, rd3, m2r3, rw3, sa3, epc3;
    logic [1:0] sb3, ps3;
    logic [2:0] ao3;
    logic [4:0] st3;
    logic [17:0] o1, o3;

    assign o1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, sa1, sb1, ao1, ps1, epc1};
    assign o3 = {pcw3, pcwc3, iord3, mr3, mw3, irw3, rd3, m2r3, rw3, sa3, sb3, ao3, ps3, epc3};

    mc_control_unit #(.MEM_WAIT(1)) u1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1),
        .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1), .RegDst(rd1), .MemtoReg(m2r1),
        .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(ao1), .PCSource(ps1),
        .EPCWrite(epc1), .state(st1)
    );

    mc_control_unit #(.MEM_WAIT(3)) u3 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .PCWrite(pcw3), .PCWriteCond(pcwc3), .IorD(iord3),
        .MemRead(mr3), .MemWrite(mw3), .IRWrite(irw3), .RegDst(rd3), .MemtoReg(m2r3),
        .RegWrite(rw3), .ALUSrcA(sa3), .ALUSrcB(sb3), .ALUOp(ao3), .PCSource(ps3),
        .EPCWrite(epc3), .state(st3)
    );

    task automatic v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ov, input logic [4:0] st,
                     input logic [17:0] o);
        vec_t e;
        e.rst = r; e.op = op; e.fn = fn; e.z = z; e.ov = ov; e.st = st; e.out = o;
        tab.push_back(e);
    endtask

    // DECODE, R_EXEC, R_WB, FETCH for one R-type instruction on the MEM_WAIT=1 instance
    task automatic rtype(input logic [5:0] fn, input logic ov, input logic [17:0] o_exec);
        v(0, 6'h00, fn, 0, ov, ST_DEC, O_DEC);
        v(0, 6'h00, fn, 0, ov, ST_REX, o_exec);
        v(0, 6'h00, fn, 0, ov, ST_RWB, O_RWB);
        v(0, 6'h00, fn, 0, ov, ST_FETCH, O_FL);
    endtask

    task automatic run(input int dut, input string tag);
        logic [4:0]  gs;
        logic [17:0] go;
        for (int i = 0; i < tab.size(); i++) begin
            reset    = tab[i].rst;
            opcode   = tab[i].op;
            funct    = tab[i].fn;
            zero     = tab[i].z;
            overflow = tab[i].ov;
            @(posedge clk);
            #1;
            gs = (dut == 1) ? st1 : st3;
            go = (dut == 1) ? o1 : o3;
            ncmp++;
            if (gs !== tab[i].st) begin
                nfail++;
                $display("FAIL %s row %0d state: got %0d, expected %0d", tag, i, gs, tab[i].st);
            end
            ncmp++;
            if (go !== tab[i].out) begin
                nfail++;
                $display("FAIL %s row %0d outputs: got %05h, expected %05h", tag, i, go, tab[i].out);
            end
        end
        tab.delete();
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

        // MEM_WAIT=1: every instruction class
        v(1, 6'h00, 6'h00, 0, 0, ST_RST, O_ZERO);
        v(0, 6'h00, 6'h00, 0, 0, ST_FETCH, O_FL);
        rtype(6'h20, 0, O_ADD);
        rtype(6'h22, 0, O_SUB);
        rtype(6'h24, 0, O_AND);
        rtype(6'h25, 0, O_OR);
        rtype(6'h2A, 0, O_SLT);
        rtype(6'h24, 1, O_AND);   // and cannot overflow: still writes back
        v(0, 6'h08, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h08, 6'h00, 0, 0, ST_AEX, O_IMM);
        v(0, 6'h08, 6'h00, 0, 0, ST_AWB, O_AWB);
        v(0, 6'h08, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h23, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h23, 6'h00, 0, 0, ST_MADDR, O_IMM);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWR, O_LWR);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWWB, O_LWWB);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h2B, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h2B, 6'h00, 0, 0, ST_MADDR, O_IMM);
        v(0, 6'h2B, 6'h00, 0, 0, ST_SW, O_SW);
        v(0, 6'h2B, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h04, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h04, 6'h00, 0, 0, ST_BEQ, O_BEQ);
        v(0, 6'h04, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h04, 6'h00, 1, 0, ST_DEC, O_DEC);
        v(0, 6'h04, 6'h00, 1, 0, ST_BEQ, O_BEQ);
        v(0, 6'h04, 6'h00, 1, 0, ST_FETCH, O_FL);
        v(0, 6'h02, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h02, 6'h00, 0, 0, ST_J, O_J);
        v(0, 6'h02, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h3F, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h3F, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h00, 6'h3F, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h00, 6'h3F, 0, 0, ST_FETCH, O_FL);
        // addi with overflow
        v(0, 6'h08, 6'h00, 0, 1, ST_DEC, O_DEC);
        v(0, 6'h08, 6'h00, 0, 1, ST_AEX, O_IMM);
`ifdef CTRL_OVF_EXC_EN
        v(0, 6'h08, 6'h00, 0, 1, ST_EXC, O_EXC);
`else
        v(0, 6'h08, 6'h00, 0, 1, ST_AWB, O_AWB);
`endif
        v(0, 6'h08, 6'h00, 0, 0, ST_FETCH, O_FL);
        // reset held 2 cycles while in LW_READ
        v(0, 6'h23, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h23, 6'h00, 0, 0, ST_MADDR, O_IMM);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWR, O_LWR);
        v(1, 6'h23, 6'h00, 0, 0, ST_RST, O_ZERO);
        v(1, 6'h23, 6'h00, 0, 0, ST_RST, O_ZERO);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h23, 6'h00, 0, 0, ST_DEC, O_DEC);
        run(1, "mw1");

        // MEM_WAIT=3: multi-cycle fetch and load, counter cleared by reset
        v(1, 6'h00, 6'h20, 0, 0, ST_RST, O_ZERO);
        v(0, 6'h00, 6'h20, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h00, 6'h20, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h00, 6'h20, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h00, 6'h20, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h00, 6'h20, 0, 0, ST_REX, O_ADD);
        v(0, 6'h00, 6'h20, 0, 0, ST_RWB, O_RWB);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h23, 6'h00, 0, 0, ST_DEC, O_DEC);
        v(0, 6'h23, 6'h00, 0, 0, ST_MADDR, O_IMM);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWR, O_LWR);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWR, O_LWR);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWR, O_LWR);
        v(0, 6'h23, 6'h00, 0, 0, ST_LWWB, O_LWWB);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(1, 6'h23, 6'h00, 0, 0, ST_RST, O_ZERO);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FW);
        v(0, 6'h23, 6'h00, 0, 0, ST_FETCH, O_FL);
        v(0, 6'h23, 6'h00, 0, 0, ST_DEC, O_DEC);
        run(3, "mw3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
